core_step_ctrl: RTL and testbench

//   Run/halt/single-step controller for the CPU core on the TinyFPGA BX.

---
 rtl/core_step_ctrl.sv | 138 +++++++++++++
 tb/tb_core_step_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_step_ctrl.sv
// Run/halt/single-step clock-enable controller with cycle breakpoint for the CPU core.
// Optional build macro: STEP_DEBOUNCE_EN (treat i_step as a raw button: synchronise, debounce, edge-detect).
module core_step_ctrl #(
    parameter int unsigned DIV_WIDTH       = 32,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_halt,
    input  logic                 i_step,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_break_en,
    input  logic [CNT_WIDTH-1:0] i_break_cycle,
    output logic                 o_clk_en,
    output logic                 o_running,
    output logic [1:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 en_q, en_d;
    logic                 running_q;
    logic                 step_pulse;
    logic                 break_hit;

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce_cfg
        $error("core_step_ctrl: DEBOUNCE_CYCLES must be nonzero");
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q, db_level_q, db_prev_q;
    logic [DB_W-1:0] db_cnt_q;

    // Accept a new button level only after it has differed from the current one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q   <= i_step;
            sync2_q   <= sync1_q;
            db_prev_q <= db_level_q;
            if (sync2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_q <= sync2_q;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign step_pulse = db_level_q & ~db_prev_q;
`else
    assign step_pulse = i_step;
`endif

    // The pulse currently on o_clk_en is the one that would bring the count to the break value.
    assign break_hit = (state_q == ST_RUN) && en_q && i_break_en &&
                       (CNT_WIDTH'(count_q + CNT_WIDTH'(1)) == i_break_cycle);

    // Next state; en_d schedules the enable pulse for the following cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (i_halt) begin
                    state_d = ST_HALT;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                    en_d    = 1'b1;
                end else if (i_run) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_HALT;
                end else if (break_hit) begin
                    state_d = ST_BREAK;
                end else if (presc_q >= i_div) begin
                    en_d    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = DIV_WIDTH'(presc_q + DIV_WIDTH'(1));
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_HALT;
            presc_q   <= '0;
            en_q      <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            en_q      <= en_d;
            running_q <= (state_d == ST_RUN);
            if (en_q) begin
                count_q <= CNT_WIDTH'(count_q + CNT_WIDTH'(1));
            end
        end
    end

    assign o_clk_en      = en_q;
    assign o_running     = running_q;
    assign o_state       = state_q;
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed testbench for core_step_ctrl (default build; debounce vectors when STEP_DEBOUNCE_EN is defined).
module tb_core_step_ctrl;

    localparam int unsigned DIV_W  = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DB_CYC = 8;

    logic             clk = 1'b0;
    logic             i_reset, i_run, i_halt, i_step, i_break_en;
    logic [DIV_W-1:0] i_div;
    logic [CNT_W-1:0] i_break_cycle;
    logic             o_clk_en, o_running;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_cycle_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int          n;
    int          pulses;

    always #5 clk = ~clk;

    core_step_ctrl #(
        .DIV_WIDTH      (DIV_W),
        .CNT_WIDTH      (CNT_W),
        .DEBOUNCE_CYCLES(DB_CYC)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_run        (i_run),
        .i_halt       (i_halt),
        .i_step       (i_step),
        .i_div        (i_div),
        .i_break_en   (i_break_en),
        .i_break_cycle(i_break_cycle),
        .o_clk_en     (o_clk_en),
        .o_running    (o_running),
        .o_state      (o_state),
        .o_cycle_count(o_cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic hold_step(input logic lvl, input int cycles);
        i_step = lvl;
        repeat (cycles) begin
            tick();
            pulses += int'(o_clk_en);
        end
    endtask

    initial begin
        i_reset = 1'b0; i_run = 1'b0; i_halt = 1'b0; i_step = 1'b0;
        i_break_en = 1'b0; i_div = '0; i_break_cycle = '0;
        pulses = 0;
        do_reset();
        check("rst_state", o_state, 2'b00);
        check("rst_running", o_running, 1'b0);
        check("rst_clk_en", o_clk_en, 1'b0);
        check("rst_count", o_cycle_count, 0);

`ifdef STEP_DEBOUNCE_EN
        // Bounces shorter than DB_CYC must be filtered out.
        hold_step(1'b1, 4);
        hold_step(1'b0, 3);
        hold_step(1'b1, 5);
        hold_step(1'b0, 2);
        hold_step(1'b1, 3);
        hold_step(1'b0, 20);
        check("db_bounce_pulses", pulses, 0);
        check("db_bounce_count", o_cycle_count, 0);
        hold_step(1'b1, 25);
        check("db_press_pulses", pulses, 1);
        hold_step(1'b0, 25);
        check("db_release_pulses", pulses, 1);
        check("db_count", o_cycle_count, 1);
        check("db_state", o_state, 2'b00);
`else
        // Test 1: i_div=3 -> pulses on cycles 4, 8, 12 after RUN entry.
        i_div = 3; i_run = 1'b1; tick(); i_run = 1'b0;
        check("t1_state", o_state, 2'b01);
        check("t1_running", o_running, 1'b1);
        check("t1_en_c0", o_clk_en, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t1_en_c%0d", k), o_clk_en, (k % 4) == 0);
        end
        tick();
        check("t1_count", o_cycle_count, 3);
        i_halt = 1'b1; tick(); i_halt = 1'b0;
        check("t1_halt_state", o_state, 2'b00);
        check("t1_halt_running", o_running, 1'b0);
        check("t1_halt_en", o_clk_en, 1'b0);
        check("t1_halt_count", o_cycle_count, 3);

        // Test 2: single step.
        i_step = 1'b1; tick(); i_step = 1'b0;
        check("t2_state_step", o_state, 2'b10);
        check("t2_en", o_clk_en, 1'b1);
        tick();
        check("t2_state_halt", o_state, 2'b00);
        check("t2_en_off", o_clk_en, 1'b0);
        check("t2_count", o_cycle_count, 4);

        // Priority in HALT: halt beats step and run; step beats run.
        i_halt = 1'b1; i_step = 1'b1; i_run = 1'b1; tick();
        i_halt = 1'b0; i_step = 1'b0; i_run = 1'b0;
        check("pri_all_state", o_state, 2'b00);
        check("pri_all_en", o_clk_en, 1'b0);
        i_step = 1'b1; i_run = 1'b1; tick(); i_step = 1'b0; i_run = 1'b0;
        check("pri_step_state", o_state, 2'b10);
        check("pri_step_en", o_clk_en, 1'b1);
        tick();
        check("pri_step_count", o_cycle_count, 5);

        // Held step level alternates STEP/HALT.
        i_step = 1'b1;
        tick(); check("lvl_s1", o_state, 2'b10);
        tick(); check("lvl_h1", o_state, 2'b00);
        tick(); check("lvl_s2", o_state, 2'b10);
        i_step = 1'b0;
        tick(); check("lvl_h2", o_state, 2'b00);
        check("lvl_count", o_cycle_count, 7);

        // Test 3: breakpoint at 5 with i_div=0.
        do_reset();
        check("t3_rst_count", o_cycle_count, 0);
        i_div = 0; i_break_en = 1'b1; i_break_cycle = 5;
        i_run = 1'b1; tick(); i_run = 1'b0;
        check("t3_en_c0", o_clk_en, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("t3_en_c%0d", k), o_clk_en, 1'b1);
            check($sformatf("t3_cnt_c%0d", k), o_cycle_count, k - 1);
        end
        tick();
        check("t3_state", o_state, 2'b11);
        check("t3_en_off", o_clk_en, 1'b0);
        check("t3_count", o_cycle_count, 5);
        check("t3_running", o_running, 1'b0);
        tick();
        check("t3_hold_state", o_state, 2'b11);
        check("t3_hold_en", o_clk_en, 1'b0);
        // Resume must not retrigger at the same count.
        i_run = 1'b1; tick(); i_run = 1'b0;
        check("t3_resume_state", o_state, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("t3_resume_en_c%0d", k), o_clk_en, 1'b1);
        end
        tick();
        check("t3_resume_run", o_state, 2'b01);
        check("t3_resume_cnt", o_cycle_count, 8);
        i_halt = 1'b1; tick(); i_halt = 1'b0;
        check("t3_halt_state", o_state, 2'b00);
        check("t3_halt_en", o_clk_en, 1'b0);
        check("t3_halt_count", o_cycle_count, 9);

        // Test 4: halt and step together while running.
        i_break_en = 1'b0; i_div = 100;
        i_run = 1'b1; tick(); i_run = 1'b0;
        repeat (3) tick();
        i_halt = 1'b1; i_step = 1'b1; tick(); i_halt = 1'b0; i_step = 1'b0;
        check("t4_state", o_state, 2'b00);
        check("t4_en", o_clk_en, 1'b0);
        check("t4_count", o_cycle_count, 9);
        tick();
        check("t4_state2", o_state, 2'b00);
        check("t4_en2", o_clk_en, 1'b0);
        check("t4_count2", o_cycle_count, 9);

        // i_div lowered below the prescaler: next cycle pulses.
        i_div = 10; i_run = 1'b1; tick(); i_run = 1'b0;
        repeat (6) tick();
        check("div_drop_before", o_clk_en, 1'b0);
        i_div = 2; tick();
        check("div_drop_pulse", o_clk_en, 1'b1);
        check("div_drop_cnt", o_cycle_count, 9);
        tick();
        check("div_drop_after", o_clk_en, 1'b0);
        check("div_drop_cnt2", o_cycle_count, 10);
        i_halt = 1'b1; tick(); i_halt = 1'b0;

        // Reset mid-RUN kills the pending pulse and clears the count.
        i_div = 0; i_run = 1'b1; tick(); i_run = 1'b0;
        tick();
        check("rst_run_en_pre", o_clk_en, 1'b1);
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        check("rst_run_en", o_clk_en, 1'b0);
        check("rst_run_state", o_state, 2'b00);
        check("rst_run_count", o_cycle_count, 0);

        // Test 5: run to all-ones via breakpoint, then one step wraps to 0.
        i_break_en = 1'b1; i_break_cycle = '1; i_div = 0;
        i_run = 1'b1; tick(); i_run = 1'b0;
        n = 0;
        while (o_state != 2'b11 && n < 400) begin
            tick();
            n++;
        end
        check("t5_break_reached", n < 400, 1'b1);
        check("t5_count_ones", o_cycle_count, 8'hFF);
        i_step = 1'b1; tick(); i_step = 1'b0;
        check("t5_step_state", o_state, 2'b10);
        check("t5_step_en", o_clk_en, 1'b1);
        tick();
        check("t5_wrap_count", o_cycle_count, 0);
        check("t5_wrap_state", o_state, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
